// File: rtl/c2_pkg.sv
// Shared constants, shift-add term table and FSM state type for the 8/pi scaler.
package c2_pkg;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned MAG_W  = WIDTH - 1;
   localparam int unsigned ACC_W  = MAG_W + 2;
   localparam int unsigned NTERMS = 12;
   localparam int unsigned IDX_W  = 4;

   localparam logic [MAG_W-1:0] MAG_MAX = 31'h7FFF_FFFF;

   typedef enum logic {
      DIR_LEFT,
      DIR_RIGHT
   } term_dir_e;

   typedef struct packed {
      term_dir_e  dir;
      logic [4:0] shamt;
   } term_t;

   // 2 + 1/2 + 1/32 + ... approximates 8/pi; order matters only for readability.
   localparam term_t TERM_TABLE [NTERMS] = '{
      '{dir: DIR_LEFT,  shamt: 5'd1},
      '{dir: DIR_RIGHT, shamt: 5'd1},
      '{dir: DIR_RIGHT, shamt: 5'd5},
      '{dir: DIR_RIGHT, shamt: 5'd7},
      '{dir: DIR_RIGHT, shamt: 5'd8},
      '{dir: DIR_RIGHT, shamt: 5'd9},
      '{dir: DIR_RIGHT, shamt: 5'd10},
      '{dir: DIR_RIGHT, shamt: 5'd11},
      '{dir: DIR_RIGHT, shamt: 5'd14},
      '{dir: DIR_RIGHT, shamt: 5'd15},
      '{dir: DIR_RIGHT, shamt: 5'd21},
      '{dir: DIR_RIGHT, shamt: 5'd22}
   };

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_e;

endpackage

// File: rtl/c2_term_sel.sv
// Combinational term selector: zero-extended magnitude shifted by table entry idx.
module c2_term_sel
   import c2_pkg::*;
(
   input  logic [MAG_W-1:0] mag,
   input  logic [IDX_W-1:0] idx,
   output logic [ACC_W-1:0] term
);

   logic [ACC_W-1:0] mag_ext;
   term_t            entry;

   assign mag_ext = {2'b00, mag};

   always_comb begin
      entry = '{dir: DIR_RIGHT, shamt: 5'd0};
      term  = '0;
      if (32'(idx) < NTERMS) begin
         entry = TERM_TABLE[idx];
         if (entry.dir == DIR_LEFT) begin
            term = mag_ext << entry.shamt;
         end else begin
            term = mag_ext >> entry.shamt;
         end
      end
   end

endmodule

// File: rtl/c2_inv_seq.sv
// Sequential 8/pi magnitude scaler: one shift-add term per clock, saturating,
// sign passed through, valid/ready on both sides.
module c2_inv_seq
   import c2_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [MAG_W-1:0] mag_q, mag_d;
   logic             sign_q, sign_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_sat_q, out_sat_d;

   logic [ACC_W-1:0] term;
   logic [ACC_W-1:0] sum;
   logic             last_term;
   logic             over;

   c2_term_sel u_term_sel (
      .mag  (mag_q),
      .idx  (idx_q),
      .term (term)
   );

   assign sum       = acc_q + term;
   assign last_term = (idx_q == IDX_W'(NTERMS - 1));
   assign over      = (sum > {2'b00, MAG_MAX});

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      mag_d      = mag_q;
      sign_d     = sign_q;
      out_data_d = out_data_q;
      out_sat_d  = out_sat_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mag_d   = in_data[MAG_W-1:0];
               sign_d  = in_data[WIDTH-1];
               acc_d   = '0;
               idx_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = sum;
            idx_d = idx_q + 1'b1;
            if (last_term) begin
               out_data_d = {sign_q, over ? MAG_MAX : sum[MAG_W-1:0]};
               out_sat_d  = over;
               state_d    = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         acc_q      <= '0;
         mag_q      <= '0;
         sign_q     <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         mag_q      <= mag_d;
         sign_q     <= sign_d;
         out_data_q <= out_data_d;
         out_sat_q  <= out_sat_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_c2_inv_seq.sv
// Directed self-checking bench for c2_inv_seq with hand-computed expected results.
module tb_c2_inv_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_sat;
   logic        busy;

   int checks;
   int errors;

   c2_inv_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accepts one operand and waits (bounded) for out_valid; leaves out_ready low.
   task automatic run_op(input logic [31:0] data, output logic [31:0] res,
                         output logic sat, output int lat, output logic ready_high,
                         output logic timeout);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = data;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid   = 1'b0;
      in_data    = 32'hDEAD_BEEF;
      lat        = 0;
      ready_high = 1'b0;
      timeout    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) ready_high = 1'b1;
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) begin
            timeout = 1'b0;
            break;
         end
      end
      res = out_data;
      sat = out_sat;
   endtask

   task automatic release_out();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic check_op(input string name, input logic [31:0] data,
                           input logic [31:0] exp_data, input logic exp_sat);
      logic [31:0] res;
      logic        sat;
      int          lat;
      logic        rh;
      logic        to;
      run_op(data, res, sat, lat, rh, to);
      checks++;
      if (to) begin
         errors++;
         $display("FAIL %s timeout: out_valid never rose", name);
      end
      checks++;
      if (lat !== 12) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 12", name, lat);
      end
      checks++;
      if (res !== exp_data) begin
         errors++;
         $display("FAIL %s data: got %h expected %h", name, res, exp_data);
      end
      checks++;
      if (sat !== exp_sat) begin
         errors++;
         $display("FAIL %s sat: got %b expected %b", name, sat, exp_sat);
      end
      checks++;
      if (rh !== 1'b0) begin
         errors++;
         $display("FAIL %s in_ready: went high during operation", name);
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s return_idle: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                  name, in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b busy=%b out_valid=%b expected 1 0 0",
                  in_ready, busy, out_valid);
      end
      checks++;
      if (out_data !== 32'h0 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_data: out_data=%h out_sat=%b expected 0 0", out_data, out_sat);
      end
   endtask

   task automatic test_values();
      check_op("zero",     32'h0000_0000, 32'h0000_0000, 1'b0);
      check_op("neg100",   32'h8000_0064, 32'h8000_00FD, 1'b0);
      check_op("pos1024",  32'h0000_0400, 32'h0000_0A2F, 1'b0);
      check_op("negzero",  32'h8000_0000, 32'h8000_0000, 1'b0);
      check_op("max",      32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      check_op("half",     32'h4000_0000, 32'h7FFF_FFFF, 1'b1);
      check_op("neg_half", 32'hC000_0000, 32'hFFFF_FFFF, 1'b1);
      check_op("mid",      32'h3000_0000, 32'h7A3B_2240, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      logic        sat;
      int          lat;
      logic        rh;
      logic        to;
      run_op(32'h0000_0400, res, sat, lat, rh, to);
      checks++;
      if (to || res !== 32'h0000_0A2F) begin
         errors++;
         $display("FAIL bp_result: got %h timeout=%b expected 00000a2f", res, to);
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1;
         in_data  = 32'h7FFF_FFFF;
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h0000_0A2F || out_sat !== 1'b0 ||
             in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b data=%h sat=%b in_ready=%b expected 1 00000a2f 0 0",
                     i, out_valid, out_data, out_sat, in_ready);
         end
      end
      in_valid = 1'b0;
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b expected 1 0 0",
                  in_ready, out_valid, busy);
      end
   endtask

   task automatic test_reset_mid_op();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'h0000_0400;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: in_ready=%b out_valid=%b out_data=%h busy=%b expected 1 0 0 0",
                  in_ready, out_valid, out_data, busy);
      end
      check_op("after_reset", 32'h0000_0400, 32'h0000_0A2F, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_values();
      test_backpressure();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
